// File: rtl/corelet_seq_pkg.sv
// corelet_seq_pkg
//   Shared definitions for the corelet sequencer: the phase state encoding,
//   bit positions inside the 34-bit corelet instruction word, and the MAC
//   opcodes with a helper that turns an opcode into its instruction bits.
package corelet_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WFILL,
    WLOAD,
    WFLUSH,
    AFILL,
    EXEC,
    DRAIN,
    DONE
  } seq_state_e;

  localparam int INST_W       = 34;
  localparam int BIT_LOAD     = 0;
  localparam int BIT_EXEC     = 1;
  localparam int BIT_L0_WR    = 2;
  localparam int BIT_L0_RD    = 3;
  localparam int BIT_OFIFO_RD = 6;
  localparam int BIT_ACC      = 33;

  typedef enum logic [1:0] {
    MAC_NOP,
    MAC_LOAD,
    MAC_EXEC
  } mac_op_e;

  // Both MAC operations consume a vector from L0, so l0_rd rides along.
  function automatic logic [INST_W-1:0] mac_inst(input mac_op_e op);
    logic [INST_W-1:0] word;
    word = '0;
    case (op)
      MAC_LOAD: begin
        word[BIT_LOAD]  = 1'b1;
        word[BIT_L0_RD] = 1'b1;
      end
      MAC_EXEC: begin
        word[BIT_EXEC]  = 1'b1;
        word[BIT_L0_RD] = 1'b1;
      end
      default: word = '0;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/corelet_seq_counter.sv
// seq_counter
//   Loadable up-counter with enable and a terminal-count flag. The sequencer
//   reuses one instance for every phase, reloading it on each phase entry.
//   Ports:
//     clk, reset      clock, asynchronous active-low reset
//     load, load_val  synchronous load (priority over en)
//     en              increment by one
//     term            terminal value compared against the count
//     count           current count
//     tc              count == term
module seq_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         tc
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign tc = (count == term);

endmodule

// File: rtl/corelet_seq.sv
// corelet_seq
//   Sequencer upstream of the corelet. For each kernel index it fills L0 with
//   weights from xmem, loads them into the array, flushes, fills L0 with
//   activations, executes, and drains the OFIFO into pmem; after len_kij
//   kernels it pulses done.
//   Ports:
//     clk, reset                 clock, asynchronous active-low reset
//     start                      one-cycle job request (honoured in IDLE only)
//     l0_full, l0_ready          L0 full / non-empty flags
//     ofifo_valid                OFIFO holds a complete output row
//     inst                       34-bit corelet instruction word
//     xmem_cen, xmem_addr        xmem read port (cen active-low)
//     pmem_cen, pmem_wen,
//     pmem_addr                  pmem write port (active-low strobes)
//     kij                        current kernel index
//     busy, done                 job in progress / one-cycle completion pulse
//   Every output is a register. Each cycle the next state is decided first,
//   then the outputs for the first cycle of that state are computed, so a
//   phase starts issuing on the very edge that enters it.
module corelet_seq
  import corelet_seq_pkg::*;
#(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int len_nij = 36,
  parameter int len_kij = 9,
  parameter int addr_w  = 11,
  parameter int w_base  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              l0_full,
  input  logic              l0_ready,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              xmem_cen,
  output logic [addr_w-1:0] xmem_addr,
  output logic              pmem_cen,
  output logic              pmem_wen,
  output logic [addr_w-1:0] pmem_addr,
  output logic [3:0]        kij,
  output logic              busy,
  output logic              done
);

  localparam int CNT_MAX = (len_nij > row + col) ? len_nij : row + col;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [addr_w-1:0] addr_t;

  seq_state_e        state, next_state;
  cnt_t              cnt, cnt_term, cnt_load_val, eff_cnt;
  logic              cnt_tc, cnt_load, cnt_en;
  logic              entering, room, issue;
  logic [INST_W-1:0] next_inst;
  logic              next_xmem_cen, next_pmem_cen, next_pmem_wen;
  addr_t             next_xmem_addr, next_pmem_addr;
  logic [3:0]        next_kij;
  logic              next_busy, next_done;

  seq_counter #(.W(CNT_W)) u_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .term     (cnt_term),
    .count    (cnt),
    .tc       (cnt_tc)
  );

  // Items per phase: reads, pops, flush cycles or OFIFO drains.
  always_comb begin
    cnt_term = '0;
    case (state)
      WFILL, WLOAD:       cnt_term = cnt_t'(col);
      WFLUSH:             cnt_term = cnt_t'(row + col);
      AFILL, EXEC, DRAIN: cnt_term = cnt_t'(len_nij);
      default:            cnt_term = '0;
    endcase
  end

  // Fill phases stay one extra cycle so the last read's l0_wr is issued
  // while still in the phase; DRAIN likewise waits for its final pmem write.
  always_comb begin
    next_state = state;
    next_kij   = kij;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = WFILL;
          next_kij   = '0;
        end
      end
      WFILL:  if (cnt_tc && xmem_cen) next_state = WLOAD;
      WLOAD:  if (cnt_tc) next_state = WFLUSH;
      WFLUSH: if (cnt_tc) next_state = AFILL;
      AFILL:  if (cnt_tc && xmem_cen) next_state = EXEC;
      EXEC:   if (cnt_tc) next_state = DRAIN;
      DRAIN: begin
        if (cnt_tc && !inst[BIT_OFIFO_RD]) begin
          if (kij == 4'(len_kij - 1)) begin
            next_state = DONE;
          end else begin
            next_state = WFILL;
            next_kij   = kij + 4'd1;
          end
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs for the coming cycle. On a phase entry the counter is treated
  // as zero and reloaded with 1 if the first item issues right away.
  // A read issued now always produces l0_wr next cycle, and a pop issued
  // now always produces a pmem write next cycle, regardless of state.
  always_comb begin
    entering       = (next_state != state);
    eff_cnt        = entering ? '0 : cnt;
    room           = entering || !cnt_tc;
    issue          = 1'b0;
    next_inst      = '0;
    next_xmem_cen  = 1'b1;
    next_xmem_addr = xmem_addr;

    next_inst[BIT_L0_WR] = ~xmem_cen;

    case (next_state)
      WFILL: begin
        issue = room && !l0_full;
        if (issue) begin
          next_xmem_cen  = 1'b0;
          next_xmem_addr = addr_t'(w_base) + addr_t'(next_kij) * addr_t'(col)
                           + addr_t'(eff_cnt);
        end
      end
      WLOAD: begin
        issue = room && l0_ready;
        if (issue) next_inst = next_inst | mac_inst(MAC_LOAD);
      end
      WFLUSH: issue = room;
      AFILL: begin
        issue = room && !l0_full;
        if (issue) begin
          next_xmem_cen  = 1'b0;
          next_xmem_addr = addr_t'(eff_cnt);
        end
      end
      EXEC: begin
        issue = room && l0_ready;
        if (issue) next_inst = next_inst | mac_inst(MAC_EXEC);
      end
      DRAIN: begin
        issue = room && ofifo_valid;
        if (issue) next_inst[BIT_OFIFO_RD] = 1'b1;
      end
      default: issue = 1'b0;
    endcase

    next_inst[BIT_ACC] = 1'b0;

    cnt_load     = entering;
    cnt_load_val = cnt_t'(issue);
    cnt_en       = issue && !entering;

    // cnt already counts the pop being presented, hence the minus one.
    next_pmem_cen  = ~inst[BIT_OFIFO_RD];
    next_pmem_wen  = ~inst[BIT_OFIFO_RD];
    next_pmem_addr = inst[BIT_OFIFO_RD]
                     ? addr_t'(kij) * addr_t'(len_nij) + addr_t'(cnt) - addr_t'(1)
                     : pmem_addr;

    next_busy = (next_state != IDLE) && (next_state != DONE);
    next_done = (next_state == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      inst      <= '0;
      xmem_cen  <= 1'b1;
      xmem_addr <= '0;
      pmem_cen  <= 1'b1;
      pmem_wen  <= 1'b1;
      pmem_addr <= '0;
      kij       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= next_state;
      inst      <= next_inst;
      xmem_cen  <= next_xmem_cen;
      xmem_addr <= next_xmem_addr;
      pmem_cen  <= next_pmem_cen;
      pmem_wen  <= next_pmem_wen;
      pmem_addr <= next_pmem_addr;
      kij       <= next_kij;
      busy      <= next_busy;
      done      <= next_done;
    end
  end

endmodule
